// File: rtl/meduram_pkg.sv
// rtl/meduram_pkg.sv - shared types and helpers for the live-value-table RAM front end
package meduram_pkg;

    // Table initialisation FSM: INIT clears every entry, RUN serves traffic.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Width of one table entry: enough bits to name any write agent, never zero.
    function automatic int sel_width(input int nb_agents);
        return (nb_agents > 1) ? $clog2(nb_agents) : 1;
    endfunction

endpackage

// File: rtl/meduram_lvt_ram.sv
// rtl/meduram_lvt_ram.sv - live value table storage with per-agent write ports
//
// Ports:
//   clk        clock
//   init_en    clear entry init_addr to agent 0 (overrides agent writes)
//   init_addr  address being cleared
//   wren       per-agent write enable
//   wraddr     per-agent write address, agent i at [ADDR_WIDTH*i +: ADDR_WIDTH]
//   rden       table read enable
//   rdaddr     table read address
//   rdsel      registered table entry (read-first), held when rden=0
//   collide    combinational: two or more agents write the same address now
module lvt_ram #(
    parameter int NB_WRAGENT = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int SEL_WIDTH  = 1
) (
    input  logic                             clk,
    input  logic                             init_en,
    input  logic [ADDR_WIDTH-1:0]            init_addr,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr,
    input  logic                             rden,
    input  logic [ADDR_WIDTH-1:0]            rdaddr,
    output logic [SEL_WIDTH-1:0]             rdsel,
    output logic                             collide
);

    logic [SEL_WIDTH-1:0] mem [RAM_DEPTH];

    // Agents are visited in increasing index order, so when several agents
    // hit the same address the last (highest-index) assignment is the one
    // that lands in the table.
    always_ff @(posedge clk) begin
        if (init_en) begin
            mem[init_addr] <= '0;
        end else begin
            for (int i = 0; i < NB_WRAGENT; i++) begin
                if (wren[i]) begin
                    mem[wraddr[ADDR_WIDTH*i +: ADDR_WIDTH]] <= SEL_WIDTH'(i);
                end
            end
        end
        // Non-blocking read of the array returns the pre-write entry.
        if (rden) begin
            rdsel <= mem[rdaddr];
        end
    end

    always_comb begin
        collide = 1'b0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            for (int j = i + 1; j < NB_WRAGENT; j++) begin
                if (wren[i] && wren[j] &&
                    (wraddr[ADDR_WIDTH*i +: ADDR_WIDTH] == wraddr[ADDR_WIDTH*j +: ADDR_WIDTH])) begin
                    collide = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/meduram_lvt.sv
// rtl/meduram_lvt.sv - live-value-table front end for the multi-agent bank array
//
// Ports:
//   clk, srst            clock, synchronous active-high reset
//   ready                table initialised, traffic accepted
//   wren/wraddr/wrdata   per-agent write request, packed per agent
//   rden/rdaddr          read request
//   rddata/rdvalid       read response, two cycles after rden
//   collision            pulse: same-address multi-agent write last cycle
//   bank_wren/wraddr/wrdata  bank write ports (agent i -> bank i)
//   bank_rden/rdaddr     bank read ports (read broadcast to all banks)
//   bank_rddata          bank read data, one cycle after bank_rden
module meduram_lvt
    import meduram_pkg::*;
#(
    parameter int NB_WRAGENT = 2,
    parameter int ADDR_WIDTH = 9,
    parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
    parameter int DATA_WIDTH = 64,
    parameter int SEL_WIDTH  = sel_width(NB_WRAGENT)
) (
    input  logic                             clk,
    input  logic                             srst,
    output logic                             ready,
    input  logic [NB_WRAGENT-1:0]            wren,
    input  logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr,
    input  logic [DATA_WIDTH*NB_WRAGENT-1:0] wrdata,
    input  logic                             rden,
    input  logic [ADDR_WIDTH-1:0]            rdaddr,
    output logic [DATA_WIDTH-1:0]            rddata,
    output logic                             rdvalid,
    output logic                             collision,
    output logic [NB_WRAGENT-1:0]            bank_wren,
    output logic [ADDR_WIDTH*NB_WRAGENT-1:0] bank_wraddr,
    output logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_wrdata,
    output logic [NB_WRAGENT-1:0]            bank_rden,
    output logic [ADDR_WIDTH*NB_WRAGENT-1:0] bank_rdaddr,
    input  logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_rddata
);

    state_t                  state;
    state_t                  state_nxt;
    logic [ADDR_WIDTH-1:0]   cnt;
    logic [NB_WRAGENT-1:0]   run_wren;
    logic                    run_rden;
    logic [SEL_WIDTH-1:0]    rdsel;
    logic                    collide;
    logic [1:0]              rdv_q;
    logic [DATA_WIDTH-1:0]   sel_data;

    // Init FSM: one table entry cleared per cycle, RUN after the last one.
    always_ff @(posedge clk) begin
        if (srst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INIT: if (cnt == ADDR_WIDTH'(RAM_DEPTH - 1)) state_nxt = RUN;
            RUN:  state_nxt = RUN;
            default: state_nxt = INIT;
        endcase
    end

    assign ready = (state == RUN);

    // Requests are dropped entirely until the table is initialised.
    assign run_wren = wren & {NB_WRAGENT{ready}};
    assign run_rden = rden & ready;

    assign bank_wren   = run_wren;
    assign bank_wraddr = wraddr;
    assign bank_wrdata = wrdata;
    assign bank_rden   = {NB_WRAGENT{run_rden}};
    assign bank_rdaddr = {NB_WRAGENT{rdaddr}};

    lvt_ram #(
        .NB_WRAGENT (NB_WRAGENT),
        .ADDR_WIDTH (ADDR_WIDTH),
        .RAM_DEPTH  (RAM_DEPTH),
        .SEL_WIDTH  (SEL_WIDTH)
    ) u_lvt_ram (
        .clk       (clk),
        .init_en   (state == INIT),
        .init_addr (cnt),
        .wren      (run_wren),
        .wraddr    (wraddr),
        .rden      (run_rden),
        .rdaddr    (rdaddr),
        .rdsel     (rdsel),
        .collide   (collide)
    );

    // rdsel and bank data both become valid one cycle after the request;
    // the mux result is registered on the following edge.
    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NB_WRAGENT; i++) begin
            if (rdsel == SEL_WIDTH'(i)) begin
                sel_data = bank_rddata[DATA_WIDTH*i +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            rdv_q     <= '0;
            rddata    <= '0;
            collision <= 1'b0;
        end else begin
            rdv_q     <= {rdv_q[0], run_rden};
            collision <= collide;
            if (rdv_q[0]) begin
                rddata <= sel_data;
            end
        end
    end

    assign rdvalid = rdv_q[1];

endmodule

// File: tb/tb_meduram_lvt.sv
// tb/tb_meduram_lvt.sv - directed self-checking bench for meduram_lvt
module tb_meduram_lvt;

    localparam int NB = 2;
    localparam int AW = 9;
    localparam int DEPTH = 512;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            srst;
    logic            ready;
    logic [NB-1:0]   wren;
    logic [AW*NB-1:0] wraddr;
    logic [DW*NB-1:0] wrdata;
    logic            rden;
    logic [AW-1:0]   rdaddr;
    logic [DW-1:0]   rddata;
    logic            rdvalid;
    logic            collision;
    logic [NB-1:0]   bank_wren;
    logic [AW*NB-1:0] bank_wraddr;
    logic [DW*NB-1:0] bank_wrdata;
    logic [NB-1:0]   bank_rden;
    logic [AW*NB-1:0] bank_rdaddr;
    logic [DW*NB-1:0] bank_rddata;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    meduram_lvt #(
        .NB_WRAGENT (NB),
        .ADDR_WIDTH (AW),
        .RAM_DEPTH  (DEPTH),
        .DATA_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .ready       (ready),
        .wren        (wren),
        .wraddr      (wraddr),
        .wrdata      (wrdata),
        .rden        (rden),
        .rdaddr      (rdaddr),
        .rddata      (rddata),
        .rdvalid     (rdvalid),
        .collision   (collision),
        .bank_wren   (bank_wren),
        .bank_wraddr (bank_wraddr),
        .bank_wrdata (bank_wrdata),
        .bank_rden   (bank_rden),
        .bank_rdaddr (bank_rdaddr),
        .bank_rddata (bank_rddata)
    );

    // Bank array model: read-first BRAMs with one cycle of read latency.
    logic [DW-1:0] bmem [NB][DEPTH];
    logic [DW-1:0] brd  [NB];

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            bmem[0][a] = 64'h1000_0000_0000_0000 | 64'(a);
            bmem[1][a] = 64'h2000_0000_0000_0000 | 64'(a);
        end
    end

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (bank_rden[b]) brd[b] <= bmem[b][bank_rdaddr[AW*b +: AW]];
            if (bank_wren[b]) bmem[b][bank_wraddr[AW*b +: AW]] <= bank_wrdata[DW*b +: DW];
        end
    end

    assign bank_rddata = {brd[1], brd[0]};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wren = '0;
        rden = 1'b0;
    endtask

    task automatic do_write(input int ag, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wren = '0;
        wren[ag] = 1'b1;
        wraddr[AW*ag +: AW] = a;
        wrdata[DW*ag +: DW] = d;
        step();
        wren = '0;
    endtask

    task automatic do_read(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rden = 1'b1;
        rdaddr = a;
        step();
        rden = 1'b0;
        check({tag, "_lat1"}, 64'(rdvalid), 64'd0);
        step();
        check({tag, "_vld"}, 64'(rdvalid), 64'd1);
        check({tag, "_data"}, rddata, exp);
    endtask

    task automatic run_init(input string tag, input logic stress);
        int bad;
        bad = 0;
        srst = 1'b0;
        // optional stress: requests held high throughout INIT must be ignored
        rden = stress;
        wren = {NB{stress}};
        for (int c = 0; c < DEPTH - 1; c++) begin
            #1;
            if (ready || rdvalid || collision || (bank_wren != 0) || (bank_rden != 0)) bad++;
            step();
        end
        idle();
        check({tag, "_quiet"}, 64'(bad), 64'd0);
        check({tag, "_not_ready"}, 64'(ready), 64'd0);
        step();
        check({tag, "_ready"}, 64'(ready), 64'd1);
        check({tag, "_rdvalid"}, 64'(rdvalid), 64'd0);
    endtask

    initial begin
        srst = 1'b1;
        wren = '0;
        wraddr = '0;
        wrdata = '0;
        rden = 1'b0;
        rdaddr = '0;
        step(); step(); step();
        check("rst_ready", 64'(ready), 64'd0);
        check("rst_rdvalid", 64'(rdvalid), 64'd0);
        check("rst_collision", 64'(collision), 64'd0);
        check("rst_rddata", rddata, 64'd0);
        run_init("init", 1'b0);

        // single agent write, pass-through of bank write ports
        wren = 2'b10;
        wraddr[AW +: AW] = 9'd5;
        wrdata[DW +: DW] = 64'hAB;
        #1;
        check("wr_bank_wren", 64'(bank_wren), 64'h2);
        check("wr_bank_wraddr", 64'(bank_wraddr[AW +: AW]), 64'd5);
        check("wr_bank_wrdata", bank_wrdata[DW +: DW], 64'hAB);
        step();
        idle();
        do_read("rd5", 9'd5, 64'hAB);
        step();
        check("hold_vld", 64'(rdvalid), 64'd0);
        check("hold_data", rddata, 64'hAB);

        // never-written address comes from bank 0
        do_read("rd20", 9'd20, 64'h1000_0000_0000_0014);

        // read broadcast onto every bank read port
        rden = 1'b1;
        rdaddr = 9'd33;
        #1;
        check("bcast_rden", 64'(bank_rden), 64'h3);
        check("bcast_rdaddr", 64'(bank_rdaddr), {46'd0, 9'd33, 9'd33});
        step();
        idle();
        step();

        // overwrite sequence on address 7
        do_write(0, 9'd7, 64'h11);
        do_read("ow1", 9'd7, 64'h11);
        do_write(1, 9'd7, 64'h22);
        do_read("ow2", 9'd7, 64'h22);
        do_write(0, 9'd7, 64'h33);
        do_read("ow3", 9'd7, 64'h33);

        // same-address collision: highest agent wins, both banks written
        wren = 2'b11;
        wraddr = {9'd3, 9'd3};
        wrdata = {64'hA1, 64'hA0};
        #1;
        check("col_now", 64'(collision), 64'd0);
        step();
        idle();
        check("col_pulse", 64'(collision), 64'd1);
        step();
        check("col_end", 64'(collision), 64'd0);
        do_read("col_rd", 9'd3, 64'hA1);
        check("col_bank0", bmem[0][3], 64'hA0);

        // different addresses in the same cycle do not interact
        wren = 2'b11;
        wraddr = {9'd11, 9'd10};
        wrdata = {64'hB1, 64'hB0};
        step();
        idle();
        check("nocol", 64'(collision), 64'd0);
        do_read("nc10", 9'd10, 64'hB0);
        do_read("nc11", 9'd11, 64'hB1);

        // read-during-write: agent 1 holds 0x44, agent 0 writes 0x55 same cycle as read
        do_write(1, 9'd9, 64'h44);
        wren = 2'b01;
        wraddr[0 +: AW] = 9'd9;
        wrdata[0 +: DW] = 64'h55;
        rden = 1'b1;
        rdaddr = 9'd9;
        step();
        wren = '0;
        step();
        rden = 1'b0;
        check("rdw_old_vld", 64'(rdvalid), 64'd1);
        check("rdw_old", rddata, 64'h44);
        step();
        check("rdw_new_vld", 64'(rdvalid), 64'd1);
        check("rdw_new", rddata, 64'h55);
        step();

        // reset during back-to-back reads
        rden = 1'b1;
        rdaddr = 9'd5;
        step();
        step();
        check("mid_pre_vld", 64'(rdvalid), 64'd1);
        srst = 1'b1;
        step();
        check("mid_vld", 64'(rdvalid), 64'd0);
        check("mid_ready", 64'(ready), 64'd0);
        run_init("reinit", 1'b1);
        // table cleared again: address 5 now resolves to bank 0
        do_read("reinit5", 9'd5, 64'h1000_0000_0000_0005);
        do_read("reinit7", 9'd7, 64'h33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
